// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of fetch-time predictions, 2-bit BHT,
// mispredict redirect and BTB write port, all resolved against EX outcomes.
module branch_resolve_unit #(
    parameter int PC_WIDTH  = 32,
    parameter int IDX_WIDTH = 5,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_valid,
    input  logic [IDX_WIDTH-1:0] if_idx,
    input  logic                 if_pred_taken,
    input  logic [PC_WIDTH-1:0]  if_pred_target,
    output logic                 pred_taken,
    output logic                 q_full,
    input  logic                 ex_valid,
    input  logic                 ex_taken,
    input  logic [PC_WIDTH-1:0]  ex_target,
    input  logic [PC_WIDTH-1:0]  ex_fallthru,
    output logic                 redirect,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic                 btb_wr_en,
    output logic [IDX_WIDTH-1:0] btb_wr_idx,
    output logic [PC_WIDTH-1:0]  btb_wr_target,
    output logic [CNT_WIDTH-1:0] mispredict_cnt,
    output logic                 err_underflow
);
    localparam int PW   = $clog2(DEPTH);
    localparam int NENT = 1 << IDX_WIDTH;

    logic [PW-1:0]        wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [PW:0]          count_q, count_d;
    logic [IDX_WIDTH-1:0] idx_mem_q [DEPTH];
    logic                 tk_mem_q  [DEPTH];
    logic [PC_WIDTH-1:0]  tgt_mem_q [DEPTH];
    logic [1:0]           bht_q     [NENT];

    logic                 redirect_q, btb_wr_en_q, err_q;
    logic [PC_WIDTH-1:0]  redirect_pc_q, btb_wr_target_q;
    logic [IDX_WIDTH-1:0] btb_wr_idx_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic                 pop, push, mispredict;
    logic [IDX_WIDTH-1:0] head_idx;
    logic                 head_tk;
    logic [PC_WIDTH-1:0]  head_tgt, correct_pc;

    assign q_full     = (count_q == (PW+1)'(DEPTH));
    assign pred_taken = bht_q[if_idx][1];

    assign head_idx   = idx_mem_q[rd_ptr_q];
    assign head_tk    = tk_mem_q[rd_ptr_q];
    assign head_tgt   = tgt_mem_q[rd_ptr_q];
    assign pop        = ex_valid & (count_q != '0);
    assign mispredict = pop & ((ex_taken != head_tk) |
                               (ex_taken & head_tk & (ex_target != head_tgt)));
    // Anything fetched on the resolving edge or during the redirect cycle is wrong-path.
    assign push       = if_valid & ~q_full & ~(mispredict | redirect_q);
    assign correct_pc = ex_taken ? ex_target : ex_fallthru;

    always_comb begin
        count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        if (mispredict) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push);
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            idx_mem_q[wr_ptr_q] <= if_idx;
            tk_mem_q[wr_ptr_q]  <= if_pred_taken;
            tgt_mem_q[wr_ptr_q] <= if_pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++) bht_q[i] <= 2'b01;
        end else if (pop) begin
            if (ex_taken && bht_q[head_idx] != 2'b11)
                bht_q[head_idx] <= bht_q[head_idx] + 2'b01;
            else if (!ex_taken && bht_q[head_idx] != 2'b00)
                bht_q[head_idx] <= bht_q[head_idx] - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_q      <= 1'b0;
            redirect_pc_q   <= '0;
            btb_wr_en_q     <= 1'b0;
            btb_wr_idx_q    <= '0;
            btb_wr_target_q <= '0;
            cnt_q           <= '0;
            err_q           <= 1'b0;
        end else begin
            redirect_q  <= mispredict;
            btb_wr_en_q <= pop & ex_taken;
            if (mispredict) begin
                redirect_pc_q <= correct_pc;
                if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end
            if (pop & ex_taken) begin
                btb_wr_idx_q    <= head_idx;
                btb_wr_target_q <= ex_target;
            end
            if (ex_valid && count_q == '0) err_q <= 1'b1;
        end
    end

    assign redirect       = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign btb_wr_en      = btb_wr_en_q;
    assign btb_wr_idx     = btb_wr_idx_q;
    assign btb_wr_target  = btb_wr_target_q;
    assign mispredict_cnt = cnt_q;
    assign err_underflow  = err_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios with constant expectations,
// then randomized traffic against a queue/array reference model.
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, if_pred_taken, ex_valid, ex_taken;
    logic [4:0]  if_idx;
    logic [31:0] if_pred_target, ex_target, ex_fallthru;
    logic        pred_taken, q_full, redirect, btb_wr_en, err_underflow;
    logic [31:0] redirect_pc, btb_wr_target;
    logic [4:0]  btb_wr_idx;
    logic [15:0] mispredict_cnt;

    int nchk = 0, nfail = 0;

    branch_resolve_unit dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_idx(if_idx), .if_pred_taken(if_pred_taken),
        .if_pred_target(if_pred_target), .pred_taken(pred_taken), .q_full(q_full),
        .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_fallthru(ex_fallthru), .redirect(redirect), .redirect_pc(redirect_pc),
        .btb_wr_en(btb_wr_en), .btb_wr_idx(btb_wr_idx), .btb_wr_target(btb_wr_target),
        .mispredict_cnt(mispredict_cnt), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // Reference model: prediction records in a queue, BHT as integer counters.
    typedef struct packed {logic [4:0] idx; logic tk; logic [31:0] tgt;} rec_t;
    rec_t        mq[$];
    int          bht[32];
    bit          e_redir, e_wen, e_err;
    logic [31:0] e_rpc, e_wtgt;
    logic [4:0]  e_widx;
    int          e_cnt;

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) bht[i] = 1;
        e_redir = 0; e_wen = 0; e_err = 0; e_rpc = 0; e_wtgt = 0; e_widx = 0; e_cnt = 0;
    endtask

    task automatic drive(input bit v, input int idx, input bit ptk, input logic [31:0] ptgt,
                         input bit ev, input bit etk, input logic [31:0] etgt,
                         input logic [31:0] efall);
        if_valid = v; if_idx = 5'(idx); if_pred_taken = ptk; if_pred_target = ptgt;
        ex_valid = ev; ex_taken = etk; ex_target = etgt; ex_fallthru = efall;
        #1;
    endtask

    // Advance one clock, updating the model from the inputs presented before the edge.
    task automatic tick();
        bit pop, mis, push, nwen;
        rec_t h;
        pop = ex_valid && mq.size() > 0;
        mis = 0; nwen = 0;
        if (ex_valid && mq.size() == 0) e_err = 1;
        if (pop) begin
            h = mq[0];
            mis = (ex_taken != h.tk) || (ex_taken && h.tk && ex_target != h.tgt);
        end
        push = if_valid && mq.size() != 4 && !mis && !e_redir;
        if (pop) begin
            if (ex_taken) begin
                bht[h.idx] = (bht[h.idx] == 3) ? 3 : bht[h.idx] + 1;
                nwen = 1; e_widx = h.idx; e_wtgt = ex_target;
            end else begin
                bht[h.idx] = (bht[h.idx] == 0) ? 0 : bht[h.idx] - 1;
            end
            if (mis) begin
                e_rpc = ex_taken ? ex_target : ex_fallthru;
                if (e_cnt < 65535) e_cnt++;
            end
            void'(mq.pop_front());
            if (mis) mq.delete();
        end
        if (push) mq.push_back('{if_idx, if_pred_taken, if_pred_target});
        e_wen = nwen; e_redir = mis;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #20;
        nchk++;
        if ({redirect, redirect_pc, btb_wr_en, btb_wr_idx, btb_wr_target, mispredict_cnt,
             err_underflow, q_full} !== '0) begin
            nfail++;
            $display("FAIL reset_outputs: got redir=%b rpc=%h wen=%b widx=%0d wtgt=%h cnt=%0d err=%b full=%b, want all 0",
                     redirect, redirect_pc, btb_wr_en, btb_wr_idx, btb_wr_target,
                     mispredict_cnt, err_underflow, q_full);
        end
        for (int i = 0; i < 32; i++) begin
            if_idx = 5'(i); #1;
            nchk++;
            if (pred_taken !== 1'b0) begin
                nfail++; $display("FAIL reset_pred idx=%0d: got %b want 0", i, pred_taken);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_not_taken();
        drive(1, 3, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 0, 0, 32'h10); tick();
        nchk++;
        if (redirect !== 1'b0 || btb_wr_en !== 1'b0) begin
            nfail++; $display("FAIL not_taken: got redir=%b wen=%b want 0 0", redirect, btb_wr_en);
        end
        // counter[3] should now be 00: one taken resolve must leave pred_taken at 0
        drive(1, 3, 1, 32'h20, 0, 0, 0, 0); tick();
        drive(0, 3, 0, 0, 1, 1, 32'h20, 0); tick();
        nchk++;
        if (pred_taken !== 1'b0) begin
            nfail++; $display("FAIL bht3_after_nt_t: got %b want 0", pred_taken);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_correct_taken();
        drive(1, 5, 1, 32'h100, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 1, 32'h100, 32'h58); tick();
        nchk++;
        if (btb_wr_en !== 1'b1 || btb_wr_idx !== 5'd5 || btb_wr_target !== 32'h100 ||
            redirect !== 1'b0 || mispredict_cnt !== 16'd0) begin
            nfail++;
            $display("FAIL correct_taken: got wen=%b idx=%0d tgt=%h redir=%b cnt=%0d want 1 5 100 0 0",
                     btb_wr_en, btb_wr_idx, btb_wr_target, redirect, mispredict_cnt);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        nchk++;
        if (btb_wr_en !== 1'b0) begin
            nfail++; $display("FAIL wen_pulse: got %b want 0", btb_wr_en);
        end
    endtask

    task automatic test_target_mismatch();
        drive(1, 2, 1, 32'h200, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 1, 32'h240, 32'h60); tick();
        nchk++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h240 || btb_wr_en !== 1'b1 ||
            btb_wr_idx !== 5'd2 || btb_wr_target !== 32'h240 || mispredict_cnt !== 16'd1) begin
            nfail++;
            $display("FAIL target_mismatch: got redir=%b rpc=%h wen=%b idx=%0d tgt=%h cnt=%0d want 1 240 1 2 240 1",
                     redirect, redirect_pc, btb_wr_en, btb_wr_idx, btb_wr_target, mispredict_cnt);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        nchk++;
        if (redirect !== 1'b0 || redirect_pc !== 32'h240) begin
            nfail++; $display("FAIL redirect_pulse: got redir=%b rpc=%h want 0 240", redirect, redirect_pc);
        end
    endtask

    task automatic test_flush();
        drive(1, 1, 1, 32'h80, 0, 0, 0, 0); tick();
        drive(1, 4, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 6, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 10, 1, 32'h300, 1, 0, 0, 32'h48); tick();
        nchk++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h48 || btb_wr_en !== 1'b0 ||
            mispredict_cnt !== 16'd2) begin
            nfail++;
            $display("FAIL flush_redirect: got redir=%b rpc=%h wen=%b cnt=%0d want 1 48 0 2",
                     redirect, redirect_pc, btb_wr_en, mispredict_cnt);
        end
        drive(1, 10, 1, 32'h300, 0, 0, 0, 0); tick();
        drive(1, 9, 0, 0, 0, 0, 0, 0); tick();
        // head must be idx 9 (predicted not-taken), so a not-taken resolve is clean
        drive(0, 0, 0, 0, 1, 0, 0, 32'h50); tick();
        nchk++;
        if (redirect !== 1'b0 || mispredict_cnt !== 16'd2) begin
            nfail++; $display("FAIL flush_dropped: got redir=%b cnt=%0d want 0 2", redirect, mispredict_cnt);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_full_wrap();
        for (int k = 0; k < 4; k++) begin
            drive(1, 16 + k, 1, 32'h1000 + 32'(k * 4), 0, 0, 0, 0);
            nchk++;
            if (q_full !== 1'b0) begin
                nfail++; $display("FAIL full_early k=%0d: got %b want 0", k, q_full);
            end
            tick();
        end
        drive(1, 31, 1, 32'h2000, 0, 0, 0, 0);
        nchk++;
        if (q_full !== 1'b1) begin
            nfail++; $display("FAIL full_set: got %b want 1", q_full);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 1, 1, 32'h1000 + 32'(k * 4), 0); tick();
            nchk++;
            if (btb_wr_en !== 1'b1 || btb_wr_idx !== 5'(16 + k) || redirect !== 1'b0) begin
                nfail++; $display("FAIL drain k=%0d: got wen=%b idx=%0d redir=%b want 1 %0d 0",
                                  k, btb_wr_en, btb_wr_idx, redirect, 16 + k);
            end
        end
        for (int k = 0; k < 10; k++) begin
            drive(1, 8 + k, 1, 32'h3000 + 32'(k * 4), 0, 0, 0, 0); tick();
            drive(0, 0, 0, 0, 1, 1, 32'h3000 + 32'(k * 4), 0); tick();
            nchk++;
            if (btb_wr_en !== 1'b1 || btb_wr_idx !== 5'(8 + k) ||
                btb_wr_target !== 32'h3000 + 32'(k * 4) || redirect !== 1'b0) begin
                nfail++; $display("FAIL wrap k=%0d: got wen=%b idx=%0d tgt=%h redir=%b",
                                  k, btb_wr_en, btb_wr_idx, btb_wr_target, redirect);
            end
        end
    endtask

    task automatic test_bht_underflow();
        drive(0, 7, 0, 0, 0, 0, 0, 0);
        nchk++;
        if (pred_taken !== 1'b0) begin
            nfail++; $display("FAIL bht7_init: got %b want 0", pred_taken);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 7, 1, 32'h700, 0, 0, 0, 0); tick();
            drive(0, 7, 0, 0, 1, 1, 32'h700, 0); tick();
            if (k == 2) begin
                nchk++;
                if (pred_taken !== 1'b1) begin
                    nfail++; $display("FAIL bht7_taken3: got %b want 1", pred_taken);
                end
            end
        end
        drive(1, 7, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 7, 0, 0, 1, 0, 0, 32'h704); tick();
        nchk++;
        if (pred_taken !== 1'b1) begin
            nfail++; $display("FAIL bht7_saturate: got %b want 1", pred_taken);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        nchk++;
        if (err_underflow !== 1'b0) begin
            nfail++; $display("FAIL underflow_pre: got %b want 0", err_underflow);
        end
        drive(0, 0, 0, 0, 1, 1, 32'h999, 0); tick();
        nchk++;
        if (err_underflow !== 1'b1 || redirect !== 1'b0 || btb_wr_en !== 1'b0 ||
            mispredict_cnt !== 16'd2) begin
            nfail++; $display("FAIL underflow: got err=%b redir=%b wen=%b cnt=%0d want 1 0 0 2",
                              err_underflow, redirect, btb_wr_en, mispredict_cnt);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        nchk++;
        if (err_underflow !== 1'b1) begin
            nfail++; $display("FAIL underflow_sticky: got %b want 1", err_underflow);
        end
    endtask

    task automatic test_random_back_to_back();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst_n = 1'b0; #1;
                model_reset();
                nchk++;
                if (redirect !== 1'b0 || btb_wr_en !== 1'b0 || q_full !== 1'b0 ||
                    mispredict_cnt !== 16'd0 || err_underflow !== 1'b0) begin
                    nfail++; $display("FAIL midreset: got redir=%b wen=%b full=%b cnt=%0d err=%b",
                                      redirect, btb_wr_en, q_full, mispredict_cnt, err_underflow);
                end
                drive(0, 0, 0, 0, 0, 0, 0, 0);
                @(negedge clk); rst_n = 1'b1;
                @(posedge clk); #1;
            end
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom_range(0, 1),
                  32'h100 + 32'($urandom_range(0, 1) * 4),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  32'h100 + 32'($urandom_range(0, 1) * 4), 32'h500 + 32'(i * 4));
            nchk++;
            if (q_full !== (mq.size() == 4) || pred_taken !== (bht[if_idx] >= 2)) begin
                nfail++; $display("FAIL rand_comb i=%0d: got full=%b pred=%b want %b %b",
                                  i, q_full, pred_taken, mq.size() == 4, bht[if_idx] >= 2);
            end
            tick();
            nchk++;
            if (redirect !== e_redir || redirect_pc !== e_rpc || btb_wr_en !== e_wen ||
                (e_wen && (btb_wr_idx !== e_widx || btb_wr_target !== e_wtgt)) ||
                mispredict_cnt !== 16'(e_cnt) || err_underflow !== e_err) begin
                nfail++;
                $display("FAIL rand_reg i=%0d: got redir=%b rpc=%h wen=%b idx=%0d tgt=%h cnt=%0d err=%b want %b %h %b %0d %h %0d %b",
                         i, redirect, redirect_pc, btb_wr_en, btb_wr_idx, btb_wr_target,
                         mispredict_cnt, err_underflow, e_redir, e_rpc, e_wen, e_widx,
                         e_wtgt, e_cnt, e_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_not_taken();
        test_correct_taken();
        test_target_mismatch();
        test_flush();
        test_full_wrap();
        test_bht_underflow();
        test_random_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Tracks every branch prediction issued at fetch and resolves it when the branch executes in EX. It holds in-flight predictions in an in-order queue and owns the 2-bit branch history table (BHT) that supplies the fetch-side taken/not-taken prediction. On resolution it detects mispredictions, issues the fetch redirect, and generates the single write port that updates the branch target buffer (index, target, write enable).

## Interface
Parameters:
- PC_WIDTH, 32, full PC / target width
- IDX_WIDTH, 5, BTB/BHT index width; table has 2^IDX_WIDTH entries
- DEPTH, 4, in-flight prediction queue entries (power of two, ≥2)
- CNT_WIDTH, 16, mispredict counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_valid  in  1  branch fetched; push prediction record
- if_idx  in  IDX_WIDTH  BTB/BHT index of fetched branch
- if_pred_taken  in  1  final taken prediction used by fetch
- if_pred_target  in  PC_WIDTH  predicted target (BTB output)
- pred_taken  out  1  BHT prediction for if_idx (combinational)
- q_full  out  1  queue full; fetch must stall branch pushes
- ex_valid  in  1  branch resolved in EX; pop oldest record
- ex_taken  in  1  actual outcome
- ex_target  in  PC_WIDTH  actual taken target
- ex_fallthru  in  PC_WIDTH  PC+4 of the branch
- redirect  out  1  one-cycle mispredict redirect pulse
- redirect_pc  out  PC_WIDTH  correct next PC
- btb_wr_en  out  1  BTB write strobe
- btb_wr_idx  out  IDX_WIDTH  BTB write index
- btb_wr_target  out  PC_WIDTH  BTB write data
- mispredict_cnt  out  CNT_WIDTH  saturating mispredict count
- err_underflow  out  1  sticky: ex_valid with empty queue

## Operation
- Queue: circular buffer, wr_ptr/rd_ptr plus count (0..DEPTH). Record = {idx, pred_taken, pred_target}.
- Push: if_valid & !q_full & !drop. q_full = (count==DEPTH), combinational from count only; a push while full is discarded even with a simultaneous pop.
- Pop: ex_valid & count!=0. Compares the head record with the outcome:
  - mispredict = (ex_taken != pred_taken) | (ex_taken & pred_taken & ex_target != pred_target).
  - correct PC = ex_taken ? ex_target : ex_fallthru.
- Mispredict at pop edge: queue cleared (count=0, rd_ptr=wr_ptr). Same-edge push dropped. redirect=1 next cycle. Pushes during redirect=1 cycle are also dropped (wrong path); drop = mispredict_now | redirect.
- BTB update: on every pop with ex_taken=1, btb_wr_en=1, btb_wr_idx=head idx, btb_wr_target=ex_target (regardless of mispredict). Not-taken pops produce no write.
- BHT: 2^IDX_WIDTH 2-bit saturating counters. Pop updates counter[head idx]: taken → +1 sat 3, not-taken → −1 sat 0. pred_taken = counter[if_idx][1]. No bypass: a same-cycle lookup of an index being updated returns the old value.
- mispredict_cnt increments per mispredict and saturates at all-ones.
- Underflow: ex_valid with count==0 sets err_underflow (cleared only by reset). No BHT, BTB, redirect, or counter effect.

## Timing
- Reset values: count=0, pointers=0, all BHT counters=2'b01 (so pred_taken=0), redirect=0, redirect_pc=0, btb_wr_en=0, btb_wr_idx=0, btb_wr_target=0, mispredict_cnt=0, err_underflow=0.
- redirect, redirect_pc, btb_wr_*: registered, valid exactly one cycle after the ex_valid edge, single-cycle pulses. redirect_pc holds its value until the next mispredict.
- pred_taken and q_full: combinational, same cycle.
- Simultaneous push+pop (not full, no mispredict): count unchanged, both pointers advance.
- Pointer wrap modulo DEPTH. Count saturation is prevented by the full check.
- Reset mid-operation: queue emptied immediately. Any pending redirect or write pulse is cancelled.

## Test plan
- Reset: all outputs 0. pred_taken=0 for every idx. Push idx 3 and resolve not-taken: no redirect, no BTB write, counter[3]=00.
- Correct taken: push {idx 5, taken, 0x100}, resolve taken 0x100 → btb_wr_en=1, idx 5, target 0x100 next cycle; redirect=0; cnt=0.
- Target mismatch: push {idx 2, taken, 0x200}, resolve taken 0x240 → redirect=1, redirect_pc=0x240, btb write 0x240, cnt=1.
- Flush: push 3 records, first resolves not-taken vs predicted taken (fallthru 0x48) → redirect_pc=0x48. Count becomes 0. The push on the resolve edge and the push during the redirect cycle are both dropped.
- Full/wrap: 4 pushes → q_full=1; a 5th push is ignored. Push/pop 10 times alternately; records are returned in order across the pointer wrap.
- BHT saturation and underflow: idx 7 resolved taken 3× → counter 11, pred_taken=1. ex_valid on an empty queue → err_underflow=1, no other outputs.
